// File: rtl/pio_pkg.sv
// Shared definitions for Avalon-MM input PIOs: register map and edge-select encodings.
package pio_pkg;

  localparam int unsigned BUS_W = 32;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/pio_sync_edge.sv
// Synchronizes asynchronous input lines and flags the selected edge type per bit.
module pio_sync_edge
  import pio_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] edge_c
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d;
  logic [WIDTH-1:0] rise_c;
  logic [WIDTH-1:0] fall_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) stage[i] <= '0;
      sync_d <= '0;
    end else begin
      stage[0] <= in_port;
      for (int i = 1; i < int'(SYNC_STAGES); i++) stage[i] <= stage[i-1];
      sync_d <= stage[SYNC_STAGES-1];
    end
  end

  assign sync   = stage[SYNC_STAGES-1];
  assign rise_c = sync & ~sync_d;
  assign fall_c = ~sync & sync_d;

  always_comb begin
    edge_c = rise_c;
    case (EDGE_TYPE)
      EDGE_FALL: edge_c = fall_c;
      EDGE_ANY:  edge_c = rise_c | fall_c;
      default:   edge_c = rise_c;
    endcase
  end

endmodule

// File: rtl/status_edge_pio.sv
// Avalon-MM input PIO: synchronized status lines, sticky edge capture and maskable level irq.
module status_edge_pio
  import pio_pkg::*;
#(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned EDGE_TYPE    = EDGE_RISE,
  parameter int unsigned BIT_CLEARING = 1,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         address,
  input  logic               chipselect,
  input  logic               read_n,
  input  logic               write_n,
  input  logic [BUS_W-1:0]   writedata,
  output logic [BUS_W-1:0]   readdata,
  input  logic [WIDTH-1:0]   in_port,
  output logic               irq
);

  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] edge_c;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] clear_c;
  logic [BUS_W-1:0] rd_mux_c;
  logic             wr_c;
  logic             rd_c;
  logic             unused_wdata_bits;

  pio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .in_port (in_port),
    .sync    (sync),
    .edge_c  (edge_c)
  );

  assign wr_c = chipselect & ~write_n;
  assign rd_c = chipselect & ~read_n;
  // Bits above WIDTH are intentionally ignored on writes.
  assign unused_wdata_bits = ^writedata;

  always_comb begin
    clear_c = '0;
    if (wr_c && (address == ADDR_EDGE)) begin
      clear_c = (BIT_CLEARING != 0) ? writedata[WIDTH-1:0] : {WIDTH{1'b1}};
    end
  end

  always_comb begin
    rd_mux_c = '0;
    case (address)
      ADDR_DATA: rd_mux_c = BUS_W'(sync);
      ADDR_MASK: rd_mux_c = BUS_W'(irq_mask);
      ADDR_EDGE: rd_mux_c = BUS_W'(edge_capture);
      default:   rd_mux_c = '0;
    endcase
  end

  // New edges are OR-ed in after the clear so a coincident set is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask     <= '0;
      edge_capture <= '0;
      readdata     <= '0;
      irq          <= 1'b0;
    end else begin
      if (wr_c && (address == ADDR_MASK)) irq_mask <= writedata[WIDTH-1:0];
      edge_capture <= (edge_capture & ~clear_c) | edge_c;
      if (rd_c) readdata <= rd_mux_c;
      irq <= |(edge_capture & irq_mask);
    end
  end

endmodule
